// File: rtl/td4_pkg.sv
// td4_pkg: shared state/opcode encodings and datapath widths for the TD4 execution controller
package td4_pkg;
    localparam int ADDR_W = 4;
    localparam int INST_W = 8;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_LOAD = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OP_RUN  = 2'b00,
        OP_STEP = 2'b01,
        OP_HALT = 2'b10,
        OP_LOAD = 2'b11
    } op_e;
endpackage

// File: rtl/td4_exec_ctrl_if.sv
// td4_exec_ctrl_if: host command, program-memory write, core and status signals of the controller
interface td4_exec_ctrl_if;
    import td4_pkg::*;
    logic              cmd_valid;
    logic              cmd_ready;
    op_e               cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [INST_W-1:0] cmd_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [INST_W-1:0] ram_wdata;
    logic              core_en;
    logic [ADDR_W-1:0] core_ip;
    logic              brk_en;
    logic [ADDR_W-1:0] brk_addr;
    state_e            state;
    logic              brk_hit;
    logic              err;
    logic [INST_W-1:0] retired;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, core_ip, brk_en, brk_addr,
        input  cmd_ready, ram_we, ram_waddr, ram_wdata, core_en, state, brk_hit, err, retired
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, core_ip, brk_en, brk_addr,
        output cmd_ready, ram_we, ram_waddr, ram_wdata, core_en, state, brk_hit, err, retired
    );
endinterface

// File: rtl/td4_en_div.sv
// td4_en_div: RUN_DIV pulse scheduler; tick announces that the coming RUN cycle is a pulse slot
module td4_en_div #(
    parameter int unsigned RUN_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);
    logic [7:0] cnt_q, cnt_d, pos;

    // cnt_q is the position (1..RUN_DIV) of the current RUN cycle in its period, 0 when idle
    always_comb begin
        pos   = (clear || cnt_q == 8'(RUN_DIV)) ? 8'd1 : cnt_q + 8'd1;
        cnt_d = run ? pos : 8'd0;
        tick  = run && pos == 8'(RUN_DIV);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/td4_exec_ctrl.sv
// td4_exec_ctrl: HALT/RUN/STEP/LOAD controller for a TD4 core with breakpoint and retire counter
module td4_exec_ctrl
    import td4_pkg::*;
#(
    parameter int unsigned RUN_DIV = 1
) (
    input logic            clock,
    input logic            reset,
    td4_exec_ctrl_if.slave bus
);
    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d, ram_we_q, ram_we_d, core_en_q, core_en_d;
    logic              brk_hit_q, brk_hit_d, err_q, err_d, first_q, first_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic [INST_W-1:0] ram_wdata_q, ram_wdata_d, retired_q, retired_d;
    logic              acc, in_halt, in_run, div_clear, div_run, tick, first, bp, pulse, step_go, load_go;

    td4_en_div #(.RUN_DIV(RUN_DIV)) u_div (
        .clock(clock),
        .reset(reset),
        .clear(div_clear),
        .run  (div_run),
        .tick (tick)
    );

    always_comb begin
        acc         = bus.cmd_valid && cmd_ready_q;
        in_halt     = state_q == ST_HALT;
        in_run      = state_q == ST_RUN;
        div_clear   = in_halt && acc && bus.cmd_op == OP_RUN;
        step_go     = in_halt && acc && bus.cmd_op == OP_STEP;
        load_go     = in_halt && acc && bus.cmd_op == OP_LOAD;
        div_run     = div_clear || (in_run && !(acc && bus.cmd_op == OP_HALT));
        // the first pulse after entering RUN steps over a breakpoint at the resume address
        first       = div_clear || first_q;
        bp          = tick && !first && bus.brk_en && bus.core_ip == bus.brk_addr;
        pulse       = tick && !bp;
        first_d     = pulse ? 1'b0 : first;
        state_d     = in_run ? ((div_run && !bp) ? ST_RUN : ST_HALT)
                    : div_clear ? ST_RUN : step_go ? ST_STEP : load_go ? ST_LOAD : ST_HALT;
        cmd_ready_d = state_d == ST_HALT || state_d == ST_RUN;
        core_en_d   = step_go || pulse;
        ram_we_d    = load_go;
        ram_waddr_d = load_go ? bus.cmd_addr : ram_waddr_q;
        ram_wdata_d = load_go ? bus.cmd_data : ram_wdata_q;
        err_d       = in_run && acc && bus.cmd_op == OP_LOAD;
        brk_hit_d   = bp ? 1'b1 : (acc && (bus.cmd_op == OP_RUN || bus.cmd_op == OP_STEP)) ? 1'b0 : brk_hit_q;
        retired_d   = load_go ? '0 : retired_q + INST_W'(core_en_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HALT;
            cmd_ready_q <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            core_en_q   <= 1'b0;
            brk_hit_q   <= 1'b0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            core_en_q   <= core_en_d;
            brk_hit_q   <= brk_hit_d;
            err_q       <= err_d;
            first_q     <= first_d;
            retired_q   <= retired_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_waddr = ram_waddr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.core_en   = core_en_q;
    assign bus.brk_hit   = brk_hit_q;
    assign bus.err       = err_q;
    assign bus.retired   = retired_q;
endmodule

// File: doc/td4_exec_ctrl.md
TD4_EXEC_CTRL -- requirements
Module: td4_exec_ctrl

Interface
REQ-001 Parameter RUN_DIV, default 1, range 1..255: clock cycles per core_en pulse in RUN.
REQ-002 Port clock, input, 1: single clock; all logic on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port cmd_valid, input, 1: host command valid.
REQ-005 Port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high in the same cycle.
REQ-006 Port cmd_op, input, 2: command opcode: 00 RUN, 01 STEP, 10 HALT, 11 LOAD.
REQ-007 Port cmd_addr, input, 4: LOAD program address.
REQ-008 Port cmd_data, input, 8: LOAD instruction byte.
REQ-009 Port ram_we, output, 1: program-memory write strobe.
REQ-010 Port ram_waddr, output, 4: program-memory write address.
REQ-011 Port ram_wdata, output, 8: program-memory write data.
REQ-012 Port core_en, output, 1: one-cycle enable for the core's register update.
REQ-013 Port core_ip, input, 4: the core's current instruction pointer.
REQ-014 Port brk_en, input, 1: breakpoint enable.
REQ-015 Port brk_addr, input, 4: breakpoint address.
REQ-016 Port state, output, 2: current state: 00 HALT, 01 RUN, 10 STEP, 11 LOAD.
REQ-017 Port brk_hit, output, 1: sticky flag, set when a breakpoint stopped execution.
REQ-018 Port err, output, 1: one-cycle pulse on an illegal command.
REQ-019 Port retired, output, 8: count of core_en pulses issued.

Function
REQ-020 All outputs shall be registered; every accepted command acts in the cycle after acceptance.
REQ-021 cmd_ready shall be high in HALT and RUN, and low in STEP and LOAD.
REQ-022 HALT state, behaviour by accepted command:
- RUN: go to RUN.
- STEP: go to STEP.
- LOAD: go to LOAD.
- HALT: no effect.
REQ-023 LOAD state shall last exactly one cycle:
- ram_we=1, with ram_waddr and ram_wdata holding the accepted cmd_addr and cmd_data.
- retired clears to 0.
- Next state is HALT.
REQ-024 STEP state shall last exactly one cycle with core_en=1, then return to HALT; breakpoints are ignored in STEP.
REQ-025 RUN pulse timing:
- A divider counter restarts on RUN entry.
- core_en pulses on the RUN_DIV-th cycle in RUN and every RUN_DIV cycles after that.
- With RUN_DIV=1, core_en is high every RUN cycle.
REQ-026 RUN, accepted HALT: go to HALT; a core_en pulse due in that same cycle is suppressed (HALT wins).
REQ-027 RUN, accepted RUN or STEP: no effect; accepted LOAD: dropped, err=1 for one cycle, no write.
REQ-028 RUN breakpoint: when a pulse is due with brk_en=1 and core_ip==brk_addr, the pulse is suppressed, state goes to HALT, and brk_hit is set.
REQ-029 Resume past a breakpoint: the first pulse after RUN entry ignores the breakpoint match, so execution continues from the breakpoint address.
REQ-030 brk_hit shall clear when a RUN or STEP command is accepted.
REQ-031 retired shall increment on each core_en pulse, wrapping 255 to 0.
REQ-032 ram_we shall never be asserted outside LOAD; core_en shall never be asserted in HALT or LOAD.

Reset
REQ-033 While reset is high, all of the following shall hold asynchronously:
- state=HALT, cmd_ready=0.
- ram_we=0, ram_waddr=0, ram_wdata=0.
- core_en=0, brk_hit=0, err=0, retired=0.
- The divider counter is 0.
REQ-034 cmd_ready shall rise in the first clock cycle after reset deasserts.
REQ-035 A reset asserted during LOAD or STEP shall abort it with no write and no enable pulse.

Structure
REQ-036 Shared package td4_pkg shall hold the state encodings, the cmd_op encodings and the 4-bit address / 8-bit instruction width constants.
REQ-037 The RUN_DIV pulse generator shall be a sub-module td4_en_div (inputs: clear, run; output: tick).
REQ-038 Target size is 120-400 lines of RTL.

Verification
REQ-039 LOAD addr=5, data=0xB7 from HALT -> one cycle with ram_we=1, ram_waddr=5, ram_wdata=0xB7; state back to HALT; retired=0.
REQ-040 STEP x3 from HALT -> exactly three single-cycle core_en pulses; retired=3; state HALT after each.
REQ-041 RUN_DIV=4, RUN, then HALT issued 10 cycles later -> core_en on cycles 4 and 8 only; retired=2.
REQ-042 brk_en=1, brk_addr=3, core_ip advancing 0,1,2,3 -> halt with core_ip=3 and brk_hit=1; a following RUN clears brk_hit and the next pulse issues at ip 3.
REQ-043 LOAD during RUN -> err pulse, no ram_we, RUN continues; HALT in the same cycle as a due pulse -> no core_en.
REQ-044 Reset asserted mid-RUN with retired=255, one more pulse first -> retired wraps to 0; after reset all outputs are at their reset values and state=HALT.
